// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction RAM address,
// issues fetched words downstream and handles branch/jump redirection with a
// single delay slot, halt on a jump to HALT_ADDR and misaligned-target faults.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] link_addr,
  output logic        instr_valid,
  output logic        in_delay_slot,
  output logic        active,
  output logic        addr_error,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pending_target;
  logic        issuing;

  // An instruction issues only on an enabled cycle while the core is running.
  assign issuing       = (state == RUN) || (state == DELAY);
  assign instr_valid   = clk_enable & issuing;
  assign instr_address = pc;
  assign instr_out     = instr_valid ? instr_readdata : '0;
  assign pc_out        = pc;
  assign link_addr     = pc + 32'd8;
  assign in_delay_slot = (state == DELAY);

  // PC sequencing, redirect/delay-slot control, fault/halt and issue counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      pending_target <= '0;
      active         <= 1'b1;
      addr_error     <= 1'b0;
      fetch_count    <= '0;
    end else if (clk_enable) begin
      if (issuing && (fetch_count != '1)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      case (state)
        RUN: begin
          if (branch_req) begin
            if (branch_target[1:0] != 2'b00) begin
              state      <= FAULT;
              addr_error <= 1'b1;
              active     <= 1'b0;
            end else begin
              pending_target <= branch_target;
              pc             <= pc + 32'd4;
              state          <= DELAY;
            end
          end else begin
            pc <= pc + 32'd4;
          end
        end
        DELAY: begin
          // Redirect requests arriving with the delay-slot word are ignored.
          if (pending_target == HALT_ADDR) begin
            pc     <= HALT_ADDR;
            state  <= HALTED;
            active <= 1'b0;
          end else begin
            pc    <= pending_target;
            state <= RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard testbench for mips_fetch_stage: a driver applies directed and
// random stimulus, a reference model predicts every cycle's outputs into a
// queue, and a monitor pops and compares against the DUT.
module tb_mips_fetch_stage;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        branch_req;
  logic [31:0] branch_target;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        instr_valid;
  logic        in_delay_slot;
  logic        active;
  logic        addr_error;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  typedef struct {
    int          step;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] link;
    logic [31:0] cnt;
    logic        valid;
    logic        ds;
    logic        act;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  mips_fetch_stage #(
    .RESET_VECTOR(32'hBFC00000),
    .HALT_ADDR   (32'h00000000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .instr_address (instr_address),
    .instr_readdata(instr_readdata),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .link_addr     (link_addr),
    .instr_valid   (instr_valid),
    .in_delay_slot (in_delay_slot),
    .active        (active),
    .addr_error    (addr_error),
    .fetch_count   (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction RAM: combinational, contents are a hash of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  assign instr_readdata = mem(instr_address);

  // Reference model: architectural view of the fetch unit.
  bit          m_known = 0;
  logic [31:0] m_pc, m_tgt, m_cnt;
  bit          m_delay, m_halt, m_fault, m_err;

  task automatic step(input bit rst, input bit en, input bit br, input logic [31:0] tgt);
    exp_t e;
    bit   running;
    @(negedge clk);
    reset         = rst;
    clk_enable    = en;
    branch_req    = br;
    branch_target = tgt;
    step_no++;
    running = !m_halt && !m_fault;
    if (m_known && !rst) begin
      e.step  = step_no;
      e.addr  = m_pc;
      e.valid = en && running;
      e.instr = e.valid ? mem(m_pc) : 32'h0;
      e.link  = m_pc + 32'd8;
      e.cnt   = m_cnt;
      e.ds    = m_delay;
      e.act   = running;
      e.err   = m_err;
      exp_q.push_back(e);
    end
    if (rst) begin
      m_known = 1;
      m_pc = RV; m_tgt = 0; m_cnt = 0;
      m_delay = 0; m_halt = 0; m_fault = 0; m_err = 0;
    end else if (en && running) begin
      if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
      if (m_delay) begin
        m_delay = 0;
        if (m_tgt == 32'h0) begin
          m_halt = 1;
          m_pc   = 32'h0;
        end else begin
          m_pc = m_tgt;
        end
      end else if (br) begin
        if (tgt % 4 != 0) begin
          m_fault = 1;
          m_err   = 1;
        end else begin
          m_tgt   = tgt;
          m_pc    = m_pc + 4;
          m_delay = 1;
        end
      end else begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic chk(input int s, input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", nm, s, got, want);
    end
  endtask

  // Monitor: every cycle with a pending prediction, compare the DUT's view.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.step, "instr_address", instr_address, e.addr);
        chk(e.step, "pc_out",        pc_out,        e.addr);
        chk(e.step, "link_addr",     link_addr,     e.link);
        chk(e.step, "instr_valid",   {31'b0, instr_valid},   {31'b0, e.valid});
        chk(e.step, "instr_out",     instr_out,     e.instr);
        chk(e.step, "in_delay_slot", {31'b0, in_delay_slot}, {31'b0, e.ds});
        chk(e.step, "active",        {31'b0, active},        {31'b0, e.act});
        chk(e.step, "addr_error",    {31'b0, addr_error},    {31'b0, e.err});
        chk(e.step, "fetch_count",   fetch_count,   e.cnt);
      end
    end
  end

  initial begin
    int idle;
    reset = 1'b1; clk_enable = 1'b0; branch_req = 1'b0; branch_target = '0;

    // Straight-line fetch from the reset vector.
    step(1, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0);

    // Branch at 0xBFC00008 to 0xBFC00040 with delay slot at 0xBFC0000C.
    step(1, 1, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    step(0, 1, 1, 32'hBFC00040);
    step(0, 1, 1, 32'hBFC00100);  // redirect in delay slot is ignored
    repeat (3) step(0, 1, 0, 0);

    // jr r0 at 0xBFC00024: delay slot issues then halt at pc 0.
    step(1, 1, 0, 0);
    repeat (9) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h0);
    repeat (4) step(0, 1, 1, 32'hBFC00000);

    // Misaligned target faults without a delay slot.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'hBFC00042);
    repeat (4) step(0, 1, 1, 32'hBFC00040);

    // Stall for four cycles inside the delay slot, then resume.
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'hBFC00080);
    repeat (4) step(0, 0, 1, 32'h0);
    repeat (3) step(0, 1, 0, 0);

    // Reset while a halt target is pending; it must never be taken.
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'h0);
    step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);

    // PC wrap through 0xFFFFFFFC to 0 is not a halt.
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'hFFFFFFF8);
    repeat (5) step(0, 1, 0, 0);

    // Randomized traffic.
    idle = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          rst, en, br;
      logic [31:0] tgt;
      int unsigned r;
      idle = (m_halt || m_fault) ? idle + 1 : 0;
      rst  = ($urandom_range(0, 99) < 2) || (idle > 4);
      en   = ($urandom_range(0, 3) != 0);
      br   = ($urandom_range(0, 4) == 0);
      r    = $urandom_range(0, 9);
      if (r == 0)      tgt = 32'h0;
      else if (r == 1) tgt = ($urandom & 32'hFFFFFFFC) | 32'($urandom_range(1, 3));
      else             tgt = RV + (32'($urandom_range(0, 255)) << 2);
      if (rst) idle = 0;
      step(rst, en, br, tgt);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
